// File: rtl/neo_coin_io_pkg.sv
// Shared types and helpers for the coin counter / lockout / G-latch block.
package neo_coin_io_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ON   = 2'd1,
    OFF  = 2'd2
  } meter_state_t;

  localparam logic SEL_COUNTER = 1'b0;
  localparam logic SEL_LOCKOUT = 1'b1;

  // One 68K access as captured alongside the strobe synchroniser.
  typedef struct packed {
    logic       a7;
    logic [2:0] addr;
  } coin_req_t;

  function automatic logic [15:0] rotl(input logic [15:0] v, input logic [3:0] n);
    return (v << n) | (v >> (5'd16 - {1'b0, n}));
  endfunction

endpackage

// File: rtl/neo_coin_meter.sv
// One coin channel: either a plain level latch or a queued, timed meter pulser.
module neo_coin_meter
  import neo_coin_io_pkg::*;
#(
  parameter int PULSE_MODE = 1,
  parameter int PULSE_ON   = 16,
  parameter int PULSE_OFF  = 16,
  parameter int PEND_W     = 3
) (
  input  logic CLK,
  input  logic nRESET,
  input  logic wr_cnt,
  input  logic dat,
  output logic counter,
  output logic dropped
);

  generate
    if (PULSE_MODE == 0) begin : g_level
      always_ff @(posedge CLK) begin
        if (!nRESET)     counter <= 1'b0;
        else if (wr_cnt) counter <= dat;
      end
      assign dropped = 1'b0;
    end else begin : g_pulse
      localparam int PMAX = (PULSE_ON > PULSE_OFF) ? PULSE_ON : PULSE_OFF;
      localparam int TW   = (PMAX > 1) ? $clog2(PMAX) : 1;
      localparam logic [TW-1:0]     T_ON     = TW'(PULSE_ON - 1);
      localparam logic [TW-1:0]     T_OFF    = TW'(PULSE_OFF - 1);
      localparam logic [PEND_W-1:0] PEND_MAX = '1;

      meter_state_t      state;
      logic [TW-1:0]     tmr;
      logic [PEND_W-1:0] pend;
      logic              inc, take, tmr_zero;

      assign inc      = wr_cnt & dat;
      assign tmr_zero = (tmr == '0);
      assign take     = (pend != '0) && ((state == IDLE) || ((state == OFF) && tmr_zero));

      // Increment and consume together cancel, so saturation is only judged
      // when the count would actually grow.
      always_ff @(posedge CLK) begin
        if (!nRESET) begin
          pend    <= '0;
          dropped <= 1'b0;
        end else if (inc && !take) begin
          if (pend == PEND_MAX) dropped <= 1'b1;
          else                  pend    <= pend + PEND_W'(1);
        end else if (take && !inc) begin
          pend <= pend - PEND_W'(1);
        end
      end

      always_ff @(posedge CLK) begin
        if (!nRESET) begin
          state   <= IDLE;
          tmr     <= '0;
          counter <= 1'b0;
        end else begin
          case (state)
            IDLE: if (take) begin
              state   <= ON;
              tmr     <= T_ON;
              counter <= 1'b1;
            end
            ON: if (tmr_zero) begin
              state   <= OFF;
              tmr     <= T_OFF;
              counter <= 1'b0;
            end else begin
              tmr <= tmr - TW'(1);
            end
            OFF: if (tmr_zero) begin
              if (take) begin
                state   <= ON;
                tmr     <= T_ON;
                counter <= 1'b1;
              end else begin
                state <= IDLE;
              end
            end else begin
              tmr <= tmr - TW'(1);
            end
            default: begin
              state   <= IDLE;
              counter <= 1'b0;
            end
          endcase
        end
      end
    end
  endgenerate

endmodule

// File: rtl/neo_coin_io.sv
// Coin counter/lockout write decode plus the rotated P-bus G capture, all on CLK.
module neo_coin_io
  import neo_coin_io_pkg::*;
#(
  parameter int CHANNELS   = 2,
  parameter int PULSE_MODE = 1,
  parameter int PULSE_ON   = 16,
  parameter int PULSE_OFF  = 16,
  parameter int PEND_W     = 3,
  parameter int G_ROT      = 4
) (
  input  logic                CLK,
  input  logic                nRESET,
  input  logic                nCOUNTOUT,
  input  logic [2:0]          M68K_ADDR,
  input  logic                M68K_ADDR_7,
  input  logic [15:0]         PBUS,
  input  logic                PCK2B,
  output logic [CHANNELS-1:0] COUNTER,
  output logic [CHANNELS-1:0] LOCKOUT,
  output logic [CHANNELS-1:0] DROPPED,
  output logic [15:0]         G
);

  localparam logic [3:0] ROT = 4'(G_ROT);

  // Strobe synchroniser; bit 2 is the previous synchronised value for edge detect.
  logic [2:0]            cnt_sync;
  logic [1:0][3:0]       req_pipe;
  coin_req_t             req;
  logic                  wr, wr_sel;
  logic [1:0]            wr_ch;
  logic [CHANNELS-1:0]   wr_cnt;

  always_ff @(posedge CLK) begin
    if (!nRESET) begin
      cnt_sync <= '0;
      req_pipe <= '0;
    end else begin
      cnt_sync <= {cnt_sync[1:0], nCOUNTOUT};
      req_pipe <= {req_pipe[0], {M68K_ADDR_7, M68K_ADDR}};
    end
  end

  // Address travels with the strobe so WR sees the values at its falling edge.
  assign req    = coin_req_t'(req_pipe[1]);
  assign wr     = cnt_sync[2] & ~cnt_sync[1];
  assign wr_ch  = {req.addr[2], req.addr[0]};
  assign wr_sel = req.addr[1];

  always_comb begin
    wr_cnt = '0;
    for (int i = 0; i < CHANNELS; i++)
      wr_cnt[i] = wr && (wr_sel == SEL_COUNTER) && (wr_ch == 2'(i));
  end

  always_ff @(posedge CLK) begin
    if (!nRESET) begin
      LOCKOUT <= '0;
    end else if (wr && (wr_sel == SEL_LOCKOUT)) begin
      for (int i = 0; i < CHANNELS; i++)
        if (wr_ch == 2'(i)) LOCKOUT[i] <= req.a7;
    end
  end

  neo_coin_meter #(
    .PULSE_MODE (PULSE_MODE),
    .PULSE_ON   (PULSE_ON),
    .PULSE_OFF  (PULSE_OFF),
    .PEND_W     (PEND_W)
  ) u_meter [CHANNELS-1:0] (
    .CLK     (CLK),
    .nRESET  (nRESET),
    .wr_cnt  (wr_cnt),
    .dat     (req.a7),
    .counter (COUNTER),
    .dropped (DROPPED)
  );

  // PBUS is delayed to match the PCK2B synchroniser so the captured word
  // is the one present at the capture edge.
  logic [2:0]       pck_sync;
  logic [1:0][15:0] pbus_pipe;

  always_ff @(posedge CLK) begin
    if (!nRESET) begin
      pck_sync  <= '0;
      pbus_pipe <= '0;
      G         <= '0;
    end else begin
      pck_sync  <= {pck_sync[1:0], PCK2B};
      pbus_pipe <= {pbus_pipe[0], PBUS};
      if (pck_sync[1] && !pck_sync[2]) G <= rotl(pbus_pipe[1], ROT);
    end
  end

endmodule

// File: doc/neo_coin_io.md
Name: neo_coin_io

Overview:
- Parametrised successor to the I0 coin counter/lockout latch and P-bus G latch, fully synchronous to the system clock CLK.
- Decodes 68K writes strobed by nCOUNTOUT into CHANNELS coin-counter and lockout channels.
- In pulse mode, each count request becomes a timed meter pulse, with saturating queueing of back-to-back requests.
- Also captures PBUS into the rotated G bus on PCK2B rising edges.

Parameters:
- CHANNELS, 2, number of coin channels, 1..4.
- PULSE_MODE, 1, 0 = legacy level latch for COUNTER, 1 = queued timed pulses.
- PULSE_ON, 16, CLK cycles COUNTER is held high per count (>=1).
- PULSE_OFF, 16, minimum CLK cycles low between pulses (>=1).
- PEND_W, 3, width of the per-channel pending-count register.
- G_ROT, 4, left-rotate amount applied to PBUS to form G (0..15).

Ports:
- CLK  in  1  system clock, all state on rising edge.
- nRESET  in  1  reset, synchronous, active-low.
- nCOUNTOUT  in  1  async 68K write strobe for the counter/lockout region, active-low.
- M68K_ADDR  in  3  address bits [3:1].
- M68K_ADDR_7  in  1  data bit carried on A7.
- PBUS  in  16  P bus.
- PCK2B  in  1  async P-bus capture clock.
- COUNTER  out  CHANNELS  coin meter drives.
- LOCKOUT  out  CHANNELS  coin lockout drives.
- DROPPED  out  CHANNELS  sticky flag: a count was lost to saturation.
- G  out  16  rotated PBUS capture.

Behaviour:
- Reset (nRESET=0 at a CLK edge): all outputs 0, pending counts 0, meter FSMs to IDLE, synchronisers cleared. Reset takes effect at that edge, including mid-pulse.
- Strobe: nCOUNTOUT passes through a 2-flop synchroniser; a falling edge of the synchronised signal gives a 1-cycle WR.
- Address and A7 are registered alongside the synchroniser, so the values sampled with WR are those at the strobe's falling edge. Exactly one WR per access, however long the strobe is held.
- Decode on WR: ch = {A3,A1}, sel = A2 (0 = counter, 1 = lockout).
  - Legacy addresses 000/001/010/011 map to counter0, counter1, lockout0, lockout1.
  - ch >= CHANNELS is ignored.
- LOCKOUT[ch] <= A7 on a lockout write. Visible 1 cycle after WR.
- PULSE_MODE=0: COUNTER[ch] <= A7 on a counter write. Visible 1 cycle after WR. DROPPED stays 0.
- PULSE_MODE=1, counter write with A7=1: pending[ch] increments, saturating at 2^PEND_W-1. An increment at saturation sets DROPPED[ch], which is cleared only by reset.
- PULSE_MODE=1, counter write with A7=0: ignored; no other effect.
- Meter FSM per channel (3 states):
  - IDLE: if pending>0, go to ON, decrement pending, load timer = PULSE_ON-1.
  - ON: COUNTER=1; timer counts down; at 0, go to OFF with timer = PULSE_OFF-1.
  - OFF: COUNTER=0; at timer 0, go to ON if pending>0 (decrement, reload PULSE_ON-1), else IDLE.
  - COUNTER is registered and reflects the state entered.
- Pulse latency: first COUNTER high 2 cycles after WR (WR cycle increments pending; IDLE consumes on the next cycle; COUNTER high the cycle after).
- Pulse timing: high exactly PULSE_ON cycles, low at least PULSE_OFF cycles between pulses.
- Simultaneous increment and consume in one cycle: pending is unchanged. Saturation is judged on the post-consume value, so no drop occurs.
- Timer width: clog2(max(PULSE_ON, PULSE_OFF)).
- G path:
  - PCK2B goes through a 2-flop synchroniser; PBUS is delayed by 2 matching register stages.
  - On a synchronised PCK2B rising edge, G <= rotl(PBUS_delayed, G_ROT).
  - G_ROT=4 gives {PBUS[11:0],PBUS[15:12]}.
  - G changes 3 CLK edges after the PCK2B rising edge and holds between edges.
- CLK must be at least 4x the PCK2B frequency and nCOUNTOUT low width at least 2 CLK periods.

Decomposition:
- Package neo_coin_io_pkg holds:
  - meter state enum IDLE/ON/OFF;
  - decode constants SEL_COUNTER=0, SEL_LOCKOUT=1;
  - rotl function.
- Sub-module neo_coin_meter holds one channel's pending register, timer, FSM, COUNTER and DROPPED. It is instantiated CHANNELS times.
- The top level holds the synchronisers, decode, LOCKOUT latches and the G path.

Test Plan:
- Reset then release → COUNTER=0, LOCKOUT=0, DROPPED=0, G=0; hold nRESET low mid-pulse → COUNTER=0 at that edge and no pulse after release.
- PULSE_MODE=0: write addr 001, A7=1, then addr 001, A7=0 → COUNTER[1] goes 1 then 0, each 1 cycle after its WR. Write addr 010, A7=1 → LOCKOUT[0]=1, other bits untouched.
- PULSE_MODE=1, PULSE_ON=16, PULSE_OFF=16: write addr 000, A7=1, holding the strobe 20 cycles → exactly one 16-cycle pulse starting 2 cycles after WR.
- Three back-to-back writes to ch0 during one pulse → 4 pulses total, each 16 high / 16 low, DROPPED=0.
- PEND_W=3: 9 writes while ch0 is busy and pending is full → pending saturates at 7, DROPPED[0]=1 and stays 1 until reset.
- PBUS=16'hABCD, pulse PCK2B → G=16'hBCDA 3 edges later. CHANNELS=2 with write to addr 100 → no output changes.
